// File: rtl/sram_port_adapter.sv
// ---------------------------------------------------------------------------
// sram_port_adapter
//
// Purpose:
//   Request/response front end for one 1RW port of a byte-masked SRAM macro
//   (e.g. sky130_sram_1rw1r_64x256_8 port 0). Requests are buffered in a small
//   FIFO and issued to the macro in strict order, at most one per cycle. Read
//   data is captured one edge after issue and returned through a
//   backpressurable response queue. A read is issued only when a response
//   slot is guaranteed, so the response queue can never overflow.
//
// Optional feature (compile-time macro):
//   SRAM_ADAPTER_WACK_EN - when defined, each write also returns a response
//   (rsp_is_wr=1, rsp_rdata=0) in order with reads and consumes credit. When
//   undefined, writes are fire-and-forget and rsp_is_wr is tied 0.
//
// Ports:
//   clk          sole clock; the macro's clk0 shares this net
//   rst          synchronous reset, active-high
//   req_valid    request present
//   req_ready    request FIFO not full
//   req_we       1=write, 0=read
//   req_wmask    byte enables (writes only)
//   req_addr     word address
//   req_wdata    write data
//   rsp_valid    response queue not empty
//   rsp_ready    consumer accepts response
//   rsp_rdata    read data of head response (0 for write acks / when empty)
//   rsp_is_wr    head response is a write ack
//   sram_csb0    active-low chip select
//   sram_web0    active-low write enable
//   sram_wmask0  byte mask
//   sram_addr0   word address
//   sram_din0    write data
//   sram_dout0   macro read data
//   busy         FIFO non-empty, response in flight, or response queue non-empty
// ---------------------------------------------------------------------------
module sram_port_adapter #(
    parameter int REQ_DEPTH  = 2,
    parameter int RSP_DEPTH  = 2,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 64,
    parameter int NUM_WMASKS = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [NUM_WMASKS-1:0] req_wmask,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_is_wr,
    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [NUM_WMASKS-1:0] sram_wmask0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    input  logic [DATA_WIDTH-1:0] sram_dout0,
    output logic                  busy
);

    localparam int RQ_PW = $clog2(REQ_DEPTH);
    localparam int RQ_CW = RQ_PW + 1;
    localparam int RS_PW = $clog2(RSP_DEPTH);
    localparam int RS_CW = RS_PW + 1;
    localparam logic [RQ_CW-1:0] RQ_FULL = RQ_CW'(REQ_DEPTH);
    localparam logic [RS_CW-1:0] RS_FULL = RS_CW'(RSP_DEPTH);

    // Request FIFO storage; contents are qualified by rq_count, so not reset.
    logic                  rq_we_mem    [REQ_DEPTH];
    logic [NUM_WMASKS-1:0] rq_wmask_mem [REQ_DEPTH];
    logic [ADDR_WIDTH-1:0] rq_addr_mem  [REQ_DEPTH];
    logic [DATA_WIDTH-1:0] rq_wdata_mem [REQ_DEPTH];
    logic [RQ_PW-1:0]      rq_wr_ptr;
    logic [RQ_PW-1:0]      rq_rd_ptr;
    logic [RQ_CW-1:0]      rq_count;

    // Response queue storage.
    logic [DATA_WIDTH-1:0] rs_data_mem [RSP_DEPTH];
    logic [RS_PW-1:0]      rs_wr_ptr;
    logic [RS_PW-1:0]      rs_rd_ptr;
    logic [RS_CW-1:0]      rs_count;

    logic                  head_we;
    logic [NUM_WMASKS-1:0] head_wmask;
    logic [ADDR_WIDTH-1:0] head_addr;
    logic [DATA_WIDTH-1:0] head_wdata;
    logic                  rq_nonempty;
    logic                  rq_push;
    logic                  issue;
    logic                  credit_ok;
    logic                  rd_pending_p1;
    logic                  rsp_pending_p1;
    logic                  rs_push;
    logic                  rs_pop;
    logic [DATA_WIDTH-1:0] rs_push_data;

`ifdef SRAM_ADAPTER_WACK_EN
    logic                  wr_pending_p1;
    logic                  rs_wr_mem [RSP_DEPTH];
`endif

    assign head_we     = rq_we_mem[rq_rd_ptr];
    assign head_wmask  = rq_wmask_mem[rq_rd_ptr];
    assign head_addr   = rq_addr_mem[rq_rd_ptr];
    assign head_wdata  = rq_wdata_mem[rq_rd_ptr];

    assign rq_nonempty = (rq_count != '0);
    assign req_ready   = (rq_count != RQ_FULL);
    assign rq_push     = req_valid && req_ready;

    // Credit counts the queued responses plus the one possibly in flight.
    // A pop on the same edge is deliberately not credited, which keeps the
    // issue path free of any dependency on rsp_ready.
    assign credit_ok   = (rs_count + RS_CW'(rsp_pending_p1)) < RS_FULL;

`ifdef SRAM_ADAPTER_WACK_EN
    assign issue          = rq_nonempty && credit_ok;
    assign rsp_pending_p1 = rd_pending_p1 || wr_pending_p1;
    assign rs_push_data   = wr_pending_p1 ? '0 : sram_dout0;
    assign rsp_is_wr      = rsp_valid && rs_wr_mem[rs_rd_ptr];
`else
    // Writes need no response slot, but a blocked read still stalls
    // everything behind it to keep strict ordering.
    assign issue          = rq_nonempty && (head_we || credit_ok);
    assign rsp_pending_p1 = rd_pending_p1;
    assign rs_push_data   = sram_dout0;
    assign rsp_is_wr      = 1'b0;
`endif

    assign rs_push   = rsp_pending_p1;
    assign rs_pop    = rsp_valid && rsp_ready;
    assign rsp_valid = (rs_count != '0);
    assign rsp_rdata = rsp_valid ? rs_data_mem[rs_rd_ptr] : '0;
    assign busy      = rq_nonempty || rsp_pending_p1 || rsp_valid;

    // Macro interface is driven straight from the FIFO head so the macro
    // samples the request on the same edge that pops it.
    always_comb begin
        sram_csb0   = 1'b1;
        sram_web0   = 1'b1;
        sram_wmask0 = '0;
        sram_addr0  = '0;
        sram_din0   = '0;
        if (issue) begin
            sram_csb0  = 1'b0;
            sram_addr0 = head_addr;
            sram_din0  = head_wdata;
            if (head_we) begin
                sram_web0   = 1'b0;
                sram_wmask0 = head_wmask;
            end
        end
    end

    // Stage p0 -> p1: request accepted / issued; in-flight flag tracks the
    // macro access whose data appears before the next edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            rq_wr_ptr     <= '0;
            rq_rd_ptr     <= '0;
            rq_count      <= '0;
            rd_pending_p1 <= 1'b0;
`ifdef SRAM_ADAPTER_WACK_EN
            wr_pending_p1 <= 1'b0;
`endif
        end else begin
            if (rq_push) begin
                rq_wr_ptr <= rq_wr_ptr + RQ_PW'(1);
            end
            if (issue) begin
                rq_rd_ptr <= rq_rd_ptr + RQ_PW'(1);
            end
            if (rq_push && !issue) begin
                rq_count <= rq_count + RQ_CW'(1);
            end else if (!rq_push && issue) begin
                rq_count <= rq_count - RQ_CW'(1);
            end
            rd_pending_p1 <= issue && !head_we;
`ifdef SRAM_ADAPTER_WACK_EN
            wr_pending_p1 <= issue && head_we;
`endif
        end
    end

    // Stage p1 -> p2: macro output captured into the response queue.
    always_ff @(posedge clk) begin
        if (rst) begin
            rs_wr_ptr <= '0;
            rs_rd_ptr <= '0;
            rs_count  <= '0;
        end else begin
            if (rs_push) begin
                rs_wr_ptr <= rs_wr_ptr + RS_PW'(1);
            end
            if (rs_pop) begin
                rs_rd_ptr <= rs_rd_ptr + RS_PW'(1);
            end
            if (rs_push && !rs_pop) begin
                rs_count <= rs_count + RS_CW'(1);
            end else if (!rs_push && rs_pop) begin
                rs_count <= rs_count - RS_CW'(1);
            end
        end
    end

    // Data storage carries no reset; validity comes from the counters above.
    always_ff @(posedge clk) begin
        if (rq_push) begin
            rq_we_mem[rq_wr_ptr]    <= req_we;
            rq_wmask_mem[rq_wr_ptr] <= req_wmask;
            rq_addr_mem[rq_wr_ptr]  <= req_addr;
            rq_wdata_mem[rq_wr_ptr] <= req_wdata;
        end
        if (rs_push) begin
            rs_data_mem[rs_wr_ptr] <= rs_push_data;
`ifdef SRAM_ADAPTER_WACK_EN
            rs_wr_mem[rs_wr_ptr]   <= wr_pending_p1;
`endif
        end
    end

    // The credit rule must make a push into a full queue impossible.
    rsp_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(rs_push && !rs_pop && (rs_count == RS_FULL)));

endmodule

// File: tb/tb_sram_port_adapter.sv
`timescale 1ns/1ps
module tb_sram_port_adapter;

    localparam int AW = 8;
    localparam int DW = 64;
    localparam int MW = 8;
`ifdef SRAM_ADAPTER_WACK_EN
    localparam bit WACK = 1'b1;
`else
    localparam bit WACK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [MW-1:0] req_wmask;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_is_wr;
    logic          sram_csb0;
    logic          sram_web0;
    logic [MW-1:0] sram_wmask0;
    logic [AW-1:0] sram_addr0;
    logic [DW-1:0] sram_din0;
    logic [DW-1:0] sram_dout0 = '0;
    logic          busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sram_port_adapter #(
        .REQ_DEPTH (2),
        .RSP_DEPTH (2),
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .NUM_WMASKS(MW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_wmask  (req_wmask),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_is_wr  (rsp_is_wr),
        .sram_csb0  (sram_csb0),
        .sram_web0  (sram_web0),
        .sram_wmask0(sram_wmask0),
        .sram_addr0 (sram_addr0),
        .sram_din0  (sram_din0),
        .sram_dout0 (sram_dout0),
        .busy       (busy)
    );

    // Behavioural macro: request captured for the coming edge, executed at
    // the negedge after that edge (masked write, or read data driven out).
    logic [DW-1:0] mem [256];
    bit            mem_init = 1'b0;
    logic          op_en    = 1'b0;
    logic          op_we    = 1'b0;
    logic [MW-1:0] op_mask  = '0;
    logic [AW-1:0] op_addr  = '0;
    logic [DW-1:0] op_din   = '0;

    always @(negedge clk) begin
        if (!mem_init) begin
            for (int k = 0; k < 256; k++) mem[k] = '0;
            mem_init = 1'b1;
        end
        if (op_en) begin
            if (op_we) begin
                for (int b = 0; b < MW; b++)
                    if (op_mask[b]) mem[op_addr][8*b +: 8] = op_din[8*b +: 8];
            end else begin
                sram_dout0 <= mem[op_addr];
            end
        end
        op_en   <= !sram_csb0;
        op_we   <= !sram_web0;
        op_mask <= sram_wmask0;
        op_addr <= sram_addr0;
        op_din  <= sram_din0;
    end

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check64(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called just after a posedge; returns #1 after the accepting edge.
    task automatic send(input logic we, input logic [AW-1:0] a, input logic [MW-1:0] m,
                        input logic [DW-1:0] d);
        int n;
        n = 0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wmask = m;
        req_wdata = d;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        check1("send_accept", req_ready, 1'b1);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 30) begin
            n++;
            @(negedge clk);
        end
        check1({name, "_idle"}, busy, 1'b0);
        check1({name, "_no_rsp"}, rsp_valid, 1'b0);
        @(posedge clk); #1;
    endtask

    logic [DW-1:0] got_data [8];
    logic          got_wr   [8];
    int            got_n;

    task automatic collect(input int want, input int budget);
        got_n = 0;
        for (int c = 0; c < budget && got_n < want; c++) begin
            @(negedge clk);
            if (rsp_valid && rsp_ready) begin
                got_data[got_n] = rsp_rdata;
                got_wr[got_n]   = rsp_is_wr;
                got_n++;
            end
        end
    endtask

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [MW-1:0] mask;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic          acc;
        logic [DW-1:0] bp_exp [5];
        logic [AW-1:0] bp_addr [5];
        int            n;

        vecs[0]  = '{1'b1, 8'h10, 8'hFF, 64'h0123456789ABCDEF, 64'h0};
        vecs[1]  = '{1'b0, 8'h10, 8'h00, 64'h0,                64'h0123456789ABCDEF};
        vecs[2]  = '{1'b1, 8'h10, 8'h0F, 64'hFFFFFFFFFFFFFFFF, 64'h0};
        vecs[3]  = '{1'b0, 8'h10, 8'h00, 64'h0,                64'h01234567FFFFFFFF};
        vecs[4]  = '{1'b1, 8'h00, 8'hFF, 64'h1111111111111111, 64'h0};
        vecs[5]  = '{1'b1, 8'h01, 8'hFF, 64'h2222222222222222, 64'h0};
        vecs[6]  = '{1'b1, 8'h02, 8'hFF, 64'h3333333333333333, 64'h0};
        vecs[7]  = '{1'b1, 8'h03, 8'hFF, 64'h4444444444444444, 64'h0};
        vecs[8]  = '{1'b1, 8'hFF, 8'h81, 64'hAAAAAAAAAAAAAAAA, 64'h0};
        vecs[9]  = '{1'b0, 8'hFF, 8'h00, 64'h0,                64'hAA000000000000AA};
        vecs[10] = '{1'b0, 8'h00, 8'h00, 64'h0,                64'h1111111111111111};
        vecs[11] = '{1'b1, 8'h01, 8'h3C, 64'h5555555555555555, 64'h0};
        vecs[12] = '{1'b0, 8'h01, 8'h00, 64'h0,                64'h2222555555552222};

        rst       = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_wmask = '0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check1("rst_req_ready", req_ready, 1'b1);
        check1("rst_rsp_valid", rsp_valid, 1'b0);
        check64("rst_rsp_rdata", rsp_rdata, 64'h0);
        check1("rst_rsp_is_wr", rsp_is_wr, 1'b0);
        check1("rst_busy", busy, 1'b0);
        check1("rst_csb0", sram_csb0, 1'b1);
        check1("rst_web0", sram_web0, 1'b1);
        check64("rst_wmask0", {56'h0, sram_wmask0}, 64'h0);
        check64("rst_addr0", {56'h0, sram_addr0}, 64'h0);
        check64("rst_din0", sram_din0, 64'h0);
        @(posedge clk); #1;

        // Table-driven single transactions with latency check
        for (int i = 0; i < NV; i++) begin
            send(vecs[i].we, vecs[i].addr, vecs[i].mask, vecs[i].wdata);
            if (!vecs[i].we || WACK) begin
                @(negedge clk);
                check1($sformatf("v%0d_valid_A0", i), rsp_valid, 1'b0);
                @(negedge clk);
                check1($sformatf("v%0d_valid_A1", i), rsp_valid, 1'b0);
                @(negedge clk);
                check1($sformatf("v%0d_valid_A2", i), rsp_valid, 1'b1);
                check64($sformatf("v%0d_rdata", i), rsp_rdata, vecs[i].exp);
                check1($sformatf("v%0d_is_wr", i), rsp_is_wr, vecs[i].we);
                @(posedge clk); #1;
            end else begin
                wait_idle($sformatf("v%0d", i));
            end
        end

        // Back-to-back reads 0x00..0x03 with rsp_ready=1
        fork
            begin
                for (int i = 0; i < 4; i++) send(1'b0, AW'(i), 8'h00, 64'h0);
            end
            collect(4, 40);
        join
        @(posedge clk); #1;
        check64("b2b_count", 64'(got_n), 64'd4);
        check64("b2b_r0", got_data[0], 64'h1111111111111111);
        check64("b2b_r1", got_data[1], 64'h2222555555552222);
        check64("b2b_r2", got_data[2], 64'h3333333333333333);
        check64("b2b_r3", got_data[3], 64'h4444444444444444);
        wait_idle("b2b");

        // Backpressure: 5 reads with rsp_ready=0
        bp_addr = '{8'h00, 8'h01, 8'h02, 8'h03, 8'hFF};
        bp_exp  = '{64'h1111111111111111, 64'h2222555555552222, 64'h3333333333333333,
                    64'h4444444444444444, 64'hAA000000000000AA};
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(1'b0, bp_addr[i], 8'h00, 64'h0);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = bp_addr[4];
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check1($sformatf("bp_csb_idle%0d", c), sram_csb0, 1'b1);
            check1($sformatf("bp_req_full%0d", c), req_ready, 1'b0);
            check1($sformatf("bp_rsp_held%0d", c), rsp_valid, 1'b1);
            check64($sformatf("bp_head%0d", c), rsp_rdata, bp_exp[0]);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        n = 0;
        for (int c = 0; c < 40 && n < 5; c++) begin
            @(negedge clk);
            acc = req_valid && req_ready;
            if (rsp_valid) begin
                got_data[n] = rsp_rdata;
                n++;
            end
            @(posedge clk); #1;
            if (acc) req_valid = 1'b0;
        end
        req_valid = 1'b0;
        check64("bp_count", 64'(n), 64'd5);
        for (int i = 0; i < 5; i++)
            check64($sformatf("bp_r%0d", i), got_data[i], bp_exp[i]);
        wait_idle("bp");

        // Write then read same address back-to-back
        fork
            begin
                send(1'b1, 8'h40, 8'hFF, 64'hDEADBEEF00C0FFEE);
                send(1'b0, 8'h40, 8'h00, 64'h0);
            end
            collect(WACK ? 2 : 1, 30);
        join
        @(posedge clk); #1;
`ifdef SRAM_ADAPTER_WACK_EN
        check64("wr_rd_count", 64'(got_n), 64'd2);
        check1("wr_rd_ack_is_wr", got_wr[0], 1'b1);
        check64("wr_rd_ack_data", got_data[0], 64'h0);
        check1("wr_rd_read_is_wr", got_wr[1], 1'b0);
        check64("wr_rd_read_data", got_data[1], 64'hDEADBEEF00C0FFEE);
`else
        check64("wr_rd_count", 64'(got_n), 64'd1);
        check1("wr_rd_read_is_wr", got_wr[0], 1'b0);
        check64("wr_rd_read_data", got_data[0], 64'hDEADBEEF00C0FFEE);
`endif
        wait_idle("wr_rd");

        // Reset the cycle after a read issue: no response may appear
        send(1'b0, 8'h10, 8'h00, 64'h0);
        @(posedge clk); #1;
        check1("rst_mid_inflight_busy", busy, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check1($sformatf("rst_mid_rsp%0d", c), rsp_valid, 1'b0);
            check1($sformatf("rst_mid_busy%0d", c), busy, 1'b0);
        end
        check1("rst_mid_req_ready", req_ready, 1'b1);
        check1("rst_mid_csb", sram_csb0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
